// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter sequencing controller
package counter_ctrl_pkg;

    // Default counter and limit width.
    localparam int CNT_W_DEF = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - synchronous up-counter with clear and enable
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, clears q
//   clr   - synchronous clear, has priority over en
//   en    - increment q by one
//   q     - counter value (wraps modulo 2^WIDTH)
module sync_up_counter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - start/pause/stop sequencing controller for an up-counter
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - synchronous active-low reset
//   start       - arm a run (honoured in IDLE only)
//   stop        - abort to IDLE from any state
//   pause       - level; freezes the count while high
//   auto_reload - 1 = periodic, 0 = one-shot; latched at start
//   limit       - terminal count; latched at start
//   count       - current count
//   busy        - high in RUN and HOLD
//   done        - one-cycle pulse at each terminal count
//   reloads     - auto-reloads since the last start (wraps)
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] reloads
);

    ctrl_state_t      state_q;
    logic [WIDTH-1:0] lim_q;
    logic             ar_q;
    logic             busy_q;
    logic             done_q;

    logic             cnt_clr;
    logic             cnt_en;
    logic             rel_clr;
    logic             rel_en;
    logic             at_limit;

    assign at_limit = (count == lim_q);

    // Counter strobes. HOLD with pause low performs the RUN action in the
    // same cycle, so a paused cycle delays the sequence by exactly one cycle.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        rel_clr = 1'b0;
        rel_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cnt_clr = 1'b1;
                    rel_clr = 1'b1;
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    cnt_clr = 1'b1;
                end else if (!pause) begin
                    if (at_limit) begin
                        if (ar_q) begin
                            cnt_clr = 1'b1;
                            rel_en  = 1'b1;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    cnt_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lim_q   <= '0;
            ar_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !stop) begin
                        lim_q   <= limit;
                        ar_q    <= auto_reload;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (pause) begin
                        done_q  <= 1'b0;
                        state_q <= HOLD;
                    end else if (at_limit) begin
                        done_q <= 1'b1;
                        if (ar_q) begin
                            state_q <= RUN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sync_up_counter #(.WIDTH(WIDTH)) u_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (count)
    );

    sync_up_counter #(.WIDTH(WIDTH)) u_reloads (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rel_clr),
        .en    (rel_en),
        .q     (reloads)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [3:0] reloads;

    int n_tests = 0;
    int n_fail  = 0;

    counter_seq_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .limit       (limit),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .reloads     (reloads)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a run is either active (counting or paused), finishing
    // (the single cycle after a one-shot terminal) or absent.
    bit       m_active;
    bit       m_finish;
    bit       m_done;
    bit       m_ar;
    bit [3:0] m_count;
    bit [3:0] m_lim;
    bit [3:0] m_rel;

    task automatic model_step(input bit r, input bit s, input bit sp, input bit pa,
                              input bit a, input bit [3:0] l);
        if (!r) begin
            m_active = 0; m_finish = 0; m_done = 0; m_ar = 0;
            m_count = 0; m_lim = 0; m_rel = 0;
        end else if (m_finish) begin
            m_finish = 0;
            m_done   = 0;
            if (sp) m_count = 0;
        end else if (m_active) begin
            if (sp) begin
                m_active = 0; m_count = 0; m_done = 0;
            end else if (pa) begin
                m_done = 0;
            end else if (m_count == m_lim) begin
                m_done = 1;
                if (m_ar) begin
                    m_count = 0;
                    m_rel   = m_rel + 4'd1;
                end else begin
                    m_active = 0;
                    m_finish = 1;
                end
            end else begin
                m_count = m_count + 4'd1;
                m_done  = 0;
            end
        end else begin
            m_done = 0;
            if (s && !sp) begin
                m_active = 1; m_lim = l; m_ar = a; m_count = 0; m_rel = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, advance model, compare #1 after the edge.
    task automatic cyc(input bit r, input bit s, input bit sp, input bit pa,
                       input bit a, input bit [3:0] l);
        rst_n = r; start = s; stop = sp; pause = pa; auto_reload = a; limit = l;
        @(posedge clk);
        model_step(r, s, sp, pa, a, l);
        #1;
        chk("model_count",   32'(count),   32'(m_count));
        chk("model_busy",    32'(busy),    32'(m_active));
        chk("model_done",    32'(done),    32'(m_done));
        chk("model_reloads", 32'(reloads), 32'(m_rel));
    endtask

    typedef struct {
        bit       r, s, sp, pa, a;
        bit [3:0] l;
        bit [3:0] e_count;
        bit       e_busy, e_done;
        bit [3:0] e_rel;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // One-shot limit=5, then reset and start+stop together in IDLE.
        tbl[0] = '{r:0, s:0, sp:0, pa:0, a:0, l:0, e_count:0, e_busy:0, e_done:0, e_rel:0};
        tbl[1] = '{r:1, s:1, sp:0, pa:0, a:0, l:5, e_count:0, e_busy:1, e_done:0, e_rel:0};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{r:1, s:0, sp:0, pa:0, a:1, l:9, e_count:4'(i - 1), e_busy:1, e_done:0, e_rel:0};
        tbl[7]  = '{r:1, s:0, sp:0, pa:0, a:0, l:0, e_count:5, e_busy:0, e_done:1, e_rel:0};
        tbl[8]  = '{r:1, s:0, sp:0, pa:0, a:0, l:0, e_count:5, e_busy:0, e_done:0, e_rel:0};
        tbl[9]  = '{r:0, s:0, sp:0, pa:0, a:0, l:0, e_count:0, e_busy:0, e_done:0, e_rel:0};
        tbl[10] = '{r:1, s:1, sp:1, pa:0, a:0, l:5, e_count:0, e_busy:0, e_done:0, e_rel:0};
        tbl[11] = '{r:1, s:0, sp:0, pa:0, a:0, l:5, e_count:0, e_busy:0, e_done:0, e_rel:0};

        rst_n = 0; start = 0; stop = 0; pause = 0; auto_reload = 0; limit = 0;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].pa, tbl[i].a, tbl[i].l);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i),  32'(done),  32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_rel", i),   32'(reloads), 32'(tbl[i].e_rel));
        end

        // Auto-reload limit=3 for 12 cycles: period 4.
        cyc(1, 1, 0, 0, 1, 3);
        for (int n = 1; n <= 12; n++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("ar3_count", 32'(count), 32'(n % 4));
            chk("ar3_done",  32'(done),  32'((n % 4) == 0));
            chk("ar3_busy",  32'(busy),  32'(1));
        end
        chk("ar3_reloads", 32'(reloads), 32'(3));
        cyc(1, 0, 1, 0, 0, 0);

        // Pause 3 cycles at count=2 with limit=6: done moves from 7 to 10 cycles.
        begin
            int  n;
            bit  found;
            cyc(1, 1, 0, 0, 0, 6);
            cyc(1, 0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0);
            chk("pause_pre_count", 32'(count), 32'(2));
            for (int i = 0; i < 3; i++) begin
                cyc(1, 0, 0, 1, 0, 0);
                chk("pause_frozen", 32'(count), 32'(2));
            end
            n = 5;
            found = 0;
            for (int i = 0; i < 20; i++) begin
                if (!found) begin
                    cyc(1, 0, 0, 0, 0, 0);
                    n++;
                    if (done === 1'b1) found = 1;
                end
            end
            chk("pause_done_cycle", 32'(n), 32'(10));
            cyc(1, 0, 0, 0, 0, 0);
        end

        // Stop on the terminal-count cycle.
        cyc(1, 1, 0, 0, 0, 2);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("stop_at_lim_pre", 32'(count), 32'(2));
        cyc(1, 0, 1, 0, 0, 0);
        chk("stop_done",  32'(done),  32'(0));
        chk("stop_count", 32'(count), 32'(0));
        chk("stop_busy",  32'(busy),  32'(0));
        cyc(1, 1, 1, 0, 0, 7);
        chk("startstop_busy",  32'(busy),  32'(0));
        chk("startstop_count", 32'(count), 32'(0));

        // limit=0 one-shot: done one cycle after start.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lim0_done", 32'(done), 32'(1));
        chk("lim0_busy", 32'(busy), 32'(0));
        cyc(1, 0, 0, 0, 0, 0);

        // limit=15 auto-reload with a stray start mid-run.
        cyc(1, 1, 0, 0, 1, 15);
        for (int n = 1; n <= 15; n++) begin
            cyc(1, (n == 5), 0, 0, 0, 3);
            chk("lim15_count", 32'(count), 32'(n));
            chk("lim15_done",  32'(done),  32'(0));
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("lim15_wrap_count", 32'(count),   32'(0));
        chk("lim15_wrap_done",  32'(done),    32'(1));
        chk("lim15_wrap_rel",   32'(reloads), 32'(1));
        chk("lim15_wrap_busy",  32'(busy),    32'(1));
        cyc(1, 0, 1, 0, 0, 0);

        // Reset mid-run at count=4.
        cyc(1, 1, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("rst_pre_count", 32'(count), 32'(4));
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_all_zero", 32'({count, busy, done, reloads}), 32'(0));
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_idle_busy",  32'(busy),  32'(0));
        chk("rst_idle_count", 32'(count), 32'(0));

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            bit       r, s, sp, pa, a;
            bit [3:0] l;
            r  = ($urandom_range(0, 63) != 0);
            s  = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 15) == 0);
            pa = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            cyc(r, s, sp, pa, a, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
